// File: rtl/usb2_ep_buf_ctrl.sv
// usb2_ep_buf_ctrl: ping-pong buffer manager for one USB2 OUT endpoint.
// Two 512-byte banks in a 1024x8 RAM; protocol writes, application reads.
// Ports:
//   phy_clk, reset_n        : clock, async active-low reset
//   pr_start/valid/data     : packet start, byte strobe, byte
//   pr_commit/abort         : packet end with good / bad CRC
//   pr_ready, pr_overflow   : ACK/NAK decision, byte-513 pulse
//   ram_we/wr_adr/wr_dat    : RAM write port
//   ram_rd_adr              : RAM read address (registered by the RAM)
//   app_avail/len           : presented bank and its byte count
//   app_rd, app_dat_valid   : read strobe, read data valid next cycle
//   app_done                : application releases the bank
//   err_cnt                 : saturating error count, only with
//                             USB2_EP_BUF_ERR_CNT_EN defined
module usb2_ep_buf_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              phy_clk,
  input  logic              reset_n,
  input  logic              pr_start,
  input  logic              pr_valid,
  input  logic [7:0]        pr_data,
  input  logic              pr_commit,
  input  logic              pr_abort,
  output logic              pr_ready,
  output logic              pr_overflow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_wr_adr,
  output logic [7:0]        ram_wr_dat,
  output logic [ADDR_W-1:0] ram_rd_adr,
  output logic              app_avail,
  output logic [LEN_W-1:0]  app_len,
  input  logic              app_rd,
  output logic              app_dat_valid,
  input  logic              app_done
`ifdef USB2_EP_BUF_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [LEN_W-1:0] BANK_L = LEN_W'(1 << (ADDR_W - 1));

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wst_t;
  typedef enum logic {R_IDLE, R_OWN} rst_t;

  wst_t              r_wst, w_wst_nxt;
  rst_t              r_rst, w_rst_nxt;
  logic [1:0]        r_full;
  logic              r_wr_sel, r_rd_sel;
  logic [LEN_W-1:0]  r_len [2];
  logic [LEN_W-1:0]  r_wcnt, r_rcnt, w_wcnt_nxt;
  logic              r_we, r_ovf, r_dv;
  logic [ADDR_W-1:0] r_wr_adr, r_rd_adr;
  logic [7:0]        r_wr_dat;
  logic              w_wr_en, w_ovf, w_commit, w_wcnt_clr;
  logic              w_rd_ok, w_done, w_rcnt_clr;
  logic [1:0]        w_set, w_clr;

  // Write FSM: pr_start always restarts, discarding any open packet.
  always_comb begin
    w_wst_nxt  = r_wst;
    w_wr_en    = 1'b0;
    w_ovf      = 1'b0;
    w_commit   = 1'b0;
    w_wcnt_clr = 1'b0;
    if (pr_start) begin
      if (!r_full[r_wr_sel]) begin
        w_wst_nxt  = W_RECV;
        w_wcnt_clr = 1'b1;
      end else begin
        w_wst_nxt = W_DROP;
      end
    end else begin
      unique case (r_wst)
        W_RECV: begin
          if (pr_valid && r_wcnt == BANK_L) begin
            w_ovf     = 1'b1;
            w_wst_nxt = W_DROP;
          end else begin
            w_wr_en = pr_valid;
            if (pr_commit) begin
              w_commit  = 1'b1;
              w_wst_nxt = W_IDLE;
            end else if (pr_abort) begin
              w_wst_nxt = W_IDLE;
            end
          end
        end
        W_DROP: begin
          if (pr_commit || pr_abort)
            w_wst_nxt = W_IDLE;
        end
        default: ;
      endcase
    end
  end

  // A byte coinciding with commit is counted into the length.
  assign w_wcnt_nxt = r_wcnt + LEN_W'(w_wr_en);

  always_comb begin
    w_rst_nxt  = r_rst;
    w_rd_ok    = 1'b0;
    w_done     = 1'b0;
    w_rcnt_clr = 1'b0;
    unique case (r_rst)
      R_IDLE: begin
        if (r_full[r_rd_sel]) begin
          w_rst_nxt  = R_OWN;
          w_rcnt_clr = 1'b1;
        end
      end
      R_OWN: begin
        w_rd_ok = app_rd && (r_rcnt < r_len[r_rd_sel]);
        if (app_done) begin
          w_done    = 1'b1;
          w_rst_nxt = R_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign w_set = w_commit ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_done ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wst <= W_IDLE;
      r_rst <= R_IDLE;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_len[0] <= '0;
      r_len[1] <= '0;
      r_wcnt   <= '0;
      r_rcnt   <= '0;
      r_we     <= 1'b0;
      r_ovf    <= 1'b0;
      r_dv     <= 1'b0;
      r_wr_adr <= '0;
      r_wr_dat <= '0;
      r_rd_adr <= '0;
    end else begin
      r_we   <= w_wr_en;
      r_ovf  <= w_ovf;
      r_dv   <= w_rd_ok;
      r_full <= (r_full | w_set) & ~w_clr;
      if (w_wr_en) begin
        r_wr_adr <= {r_wr_sel, r_wcnt[ADDR_W-2:0]};
        r_wr_dat <= pr_data;
      end
      if (w_wcnt_clr)
        r_wcnt <= '0;
      else if (w_wr_en)
        r_wcnt <= w_wcnt_nxt;
      if (w_commit) begin
        r_len[r_wr_sel] <= w_wcnt_nxt;
        r_wr_sel        <= ~r_wr_sel;
      end
      if (w_rd_ok)
        r_rd_adr <= {r_rd_sel, r_rcnt[ADDR_W-2:0]};
      if (w_rcnt_clr)
        r_rcnt <= '0;
      else if (w_rd_ok)
        r_rcnt <= r_rcnt + LEN_W'(1);
      if (w_done)
        r_rd_sel <= ~r_rd_sel;
    end
  end

`ifdef USB2_EP_BUF_ERR_CNT_EN
  logic [7:0] r_err;
  logic       w_err_evt;

  // NAKed start, overflow, or abort of an open packet; one count per cycle.
  assign w_err_evt = (pr_start & r_full[r_wr_sel]) | w_ovf |
                     ((r_wst == W_RECV) & ~pr_start & ~w_ovf &
                      ~pr_commit & pr_abort);

  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= '0;
    else if (w_err_evt && r_err != 8'hFF)
      r_err <= r_err + 8'd1;
  end

  assign err_cnt = r_err;
`endif

  assign pr_ready      = ~r_full[r_wr_sel];
  assign pr_overflow   = r_ovf;
  assign ram_we        = r_we;
  assign ram_wr_adr    = r_wr_adr;
  assign ram_wr_dat    = r_wr_dat;
  assign ram_rd_adr    = r_rd_adr;
  assign app_avail     = (r_rst == R_OWN);
  assign app_len       = app_avail ? r_len[r_rd_sel] : '0;
  assign app_dat_valid = r_dv;

endmodule

// File: tb/tb_usb2_ep_buf_ctrl.sv
// tb_usb2_ep_buf_ctrl: directed bench for usb2_ep_buf_ctrl.
// Cycle table for the basic packet, then hand sequences for corners.
module tb_usb2_ep_buf_ctrl;

  logic       phy_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pr_start = 1'b0, pr_valid = 1'b0;
  logic [7:0] pr_data = 8'h00;
  logic       pr_commit = 1'b0, pr_abort = 1'b0;
  logic       app_rd = 1'b0, app_done = 1'b0;
  logic       pr_ready, pr_overflow, ram_we, app_avail, app_dat_valid;
  logic [9:0] ram_wr_adr, ram_rd_adr, app_len;
  logic [7:0] ram_wr_dat;
`ifdef USB2_EP_BUF_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] mem [1024];

  always #5 phy_clk = ~phy_clk;

  usb2_ep_buf_ctrl #(.ADDR_W(10), .LEN_W(10)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .pr_start(pr_start), .pr_valid(pr_valid), .pr_data(pr_data),
    .pr_commit(pr_commit), .pr_abort(pr_abort),
    .pr_ready(pr_ready), .pr_overflow(pr_overflow),
    .ram_we(ram_we), .ram_wr_adr(ram_wr_adr), .ram_wr_dat(ram_wr_dat),
    .ram_rd_adr(ram_rd_adr), .app_avail(app_avail), .app_len(app_len),
    .app_rd(app_rd), .app_dat_valid(app_dat_valid), .app_done(app_done)
`ifdef USB2_EP_BUF_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // RAM write port model
  always @(posedge phy_clk) begin
    if (ram_we) begin
      mem[ram_wr_adr] <= ram_wr_dat;
      we_cnt = we_cnt + 1;
    end
  end

  typedef struct {
    logic       st, vl;
    logic [7:0] dat;
    logic       cm, ab, rd, dn;
    logic       e_rdy, e_we;
    logic [9:0] e_wadr;
    logic [7:0] e_wdat;
    logic       e_ovf, e_av;
    logic [9:0] e_len, e_radr;
    logic       e_dv;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pr_start = 0; pr_valid = 0; pr_commit = 0; pr_abort = 0;
    app_rd = 0; app_done = 0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic send(int n, logic [7:0] b, bit cm);
    pr_start = 1; tick(); pr_start = 0;
    for (int i = 0; i < n; i++) begin
      pr_valid = 1; pr_data = b + 8'(i); tick();
    end
    pr_valid = 0;
    if (cm) pr_commit = 1; else pr_abort = 1;
    tick();
    pr_commit = 0; pr_abort = 0;
  endtask

  task automatic wait_avail(string nm, int maxc);
    for (int i = 0; i < maxc && app_avail !== 1'b1; i++) tick();
    chk(nm, 32'(app_avail), 32'd1);
  endtask

  initial begin
    int we0;
    // st vl dat cm ab rd dn | rdy we wadr wdat ovf av len radr dv
    tbl[0]  = '{1,0,8'h00,0,0,0,0, 1,0,10'h000,8'h00,0,0,10'd0,10'h000,0};
    tbl[1]  = '{0,1,8'hA1,0,0,0,0, 1,1,10'h000,8'hA1,0,0,10'd0,10'h000,0};
    tbl[2]  = '{0,1,8'hA2,0,0,0,0, 1,1,10'h001,8'hA2,0,0,10'd0,10'h000,0};
    tbl[3]  = '{0,1,8'hA3,0,0,0,0, 1,1,10'h002,8'hA3,0,0,10'd0,10'h000,0};
    tbl[4]  = '{0,1,8'hA4,1,0,0,0, 1,1,10'h003,8'hA4,0,0,10'd0,10'h000,0};
    tbl[5]  = '{0,0,8'h00,0,0,0,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h000,0};
    tbl[6]  = '{0,0,8'h00,0,0,1,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h000,1};
    tbl[7]  = '{0,0,8'h00,0,0,1,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h001,1};
    tbl[8]  = '{0,0,8'h00,0,0,1,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h002,1};
    tbl[9]  = '{0,0,8'h00,0,0,1,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h003,1};
    tbl[10] = '{0,0,8'h00,0,0,1,0, 1,0,10'h003,8'hA4,0,1,10'd4,10'h003,0};
    tbl[11] = '{0,0,8'h00,0,0,0,1, 1,0,10'h003,8'hA4,0,0,10'd0,10'h003,0};
    tbl[12] = '{0,0,8'h00,0,0,0,0, 1,0,10'h003,8'hA4,0,0,10'd0,10'h003,0};

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    // reset values
    tick();
    chk("rst.ready", 32'(pr_ready), 32'd1);
    chk("rst.ovf", 32'(pr_overflow), 32'd0);
    chk("rst.we", 32'(ram_we), 32'd0);
    chk("rst.wadr", 32'(ram_wr_adr), 32'd0);
    chk("rst.wdat", 32'(ram_wr_dat), 32'd0);
    chk("rst.radr", 32'(ram_rd_adr), 32'd0);
    chk("rst.avail", 32'(app_avail), 32'd0);
    chk("rst.len", 32'(app_len), 32'd0);
    chk("rst.dv", 32'(app_dat_valid), 32'd0);
    do_reset();

    // 4-byte packet, commit on the last byte, read back
    for (int i = 0; i < 13; i++) begin
      pr_start = tbl[i].st; pr_valid = tbl[i].vl; pr_data = tbl[i].dat;
      pr_commit = tbl[i].cm; pr_abort = tbl[i].ab;
      app_rd = tbl[i].rd; app_done = tbl[i].dn;
      tick();
      chk($sformatf("v%0d.ready", i), 32'(pr_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d.we", i), 32'(ram_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d.wadr", i), 32'(ram_wr_adr), 32'(tbl[i].e_wadr));
      chk($sformatf("v%0d.wdat", i), 32'(ram_wr_dat), 32'(tbl[i].e_wdat));
      chk($sformatf("v%0d.ovf", i), 32'(pr_overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("v%0d.avail", i), 32'(app_avail), 32'(tbl[i].e_av));
      chk($sformatf("v%0d.len", i), 32'(app_len), 32'(tbl[i].e_len));
      chk($sformatf("v%0d.radr", i), 32'(ram_rd_adr), 32'(tbl[i].e_radr));
      chk($sformatf("v%0d.dv", i), 32'(app_dat_valid), 32'(tbl[i].e_dv));
    end
    pr_start = 0; pr_valid = 0; pr_commit = 0; app_rd = 0; app_done = 0;
    chk("t1.mem0", 32'(mem[0]), 32'h A1);
    chk("t1.mem3", 32'(mem[3]), 32'h A4);

    // both banks full, third packet NAKed
    do_reset();
    send(10, 8'h10, 1);
    send(3, 8'h30, 1);
    tick(); tick();
    chk("t2.ready_full", 32'(pr_ready), 32'd0);
    chk("t2.avail", 32'(app_avail), 32'd1);
    chk("t2.len10", 32'(app_len), 32'd10);
    we0 = we_cnt;
    send(4, 8'h50, 1);
    tick();
    chk("t2.nak_we", 32'(we_cnt - we0), 32'd0);
    chk("t2.ready_nak", 32'(pr_ready), 32'd0);
    chk("t2.mem009", 32'(mem[10'h009]), 32'h19);
    chk("t2.mem200", 32'(mem[10'h200]), 32'h30);
    app_done = 1; tick(); app_done = 0;
    chk("t2.ready_freed", 32'(pr_ready), 32'd1);
    chk("t2.avail_drop", 32'(app_avail), 32'd0);
    wait_avail("t2.avail_b1", 5);
    chk("t2.len3", 32'(app_len), 32'd3);
    app_rd = 1; tick(); app_rd = 0;
    chk("t2.radr", 32'(ram_rd_adr), 32'h200);
    chk("t2.dv", 32'(app_dat_valid), 32'd1);

    // 513 bytes: overflow on the last one, commit ignored
    do_reset();
    pr_start = 1; tick(); pr_start = 0;
    we0 = we_cnt;
    for (int i = 0; i < 512; i++) begin
      pr_valid = 1; pr_data = 8'(i); tick();
      if (pr_overflow !== 1'b0) chk("t3.early_ovf", 32'(pr_overflow), 32'd0);
    end
    chk("t3.last_adr", 32'(ram_wr_adr), 32'h1FF);
    pr_data = 8'hEE; tick();
    chk("t3.ovf", 32'(pr_overflow), 32'd1);
    chk("t3.no_we", 32'(ram_we), 32'd0);
    pr_valid = 0; tick();
    chk("t3.ovf_pulse", 32'(pr_overflow), 32'd0);
    chk("t3.we_cnt", 32'(we_cnt - we0), 32'd512);
    pr_commit = 1; tick(); pr_commit = 0;
    tick(); tick(); tick();
    chk("t3.avail", 32'(app_avail), 32'd0);
    chk("t3.ready", 32'(pr_ready), 32'd1);

    // abort: nothing presented, next packet restarts at 0x000
    do_reset();
    send(5, 8'h60, 0);
    tick(); tick(); tick();
    chk("t4.avail", 32'(app_avail), 32'd0);
    chk("t4.ready", 32'(pr_ready), 32'd1);
    pr_start = 1; tick(); pr_start = 0;
    pr_valid = 1; pr_data = 8'h77; tick(); pr_valid = 0;
    chk("t4.we", 32'(ram_we), 32'd1);
    chk("t4.wadr", 32'(ram_wr_adr), 32'h000);
    chk("t4.wdat", 32'(ram_wr_dat), 32'h77);
    pr_abort = 1; tick(); pr_abort = 0;

    // zero-length packet
    do_reset();
    send(0, 8'h00, 1);
    wait_avail("t5.avail", 5);
    chk("t5.len0", 32'(app_len), 32'd0);
    app_rd = 1; tick(); app_rd = 0;
    chk("t5.dv", 32'(app_dat_valid), 32'd0);
    tick();
    chk("t5.dv2", 32'(app_dat_valid), 32'd0);
    app_done = 1; tick(); app_done = 0;
    chk("t5.avail_drop", 32'(app_avail), 32'd0);
    tick(); tick();
    chk("t5.avail_stay", 32'(app_avail), 32'd0);
    send(1, 8'h88, 1);
    tick(); tick();
    chk("t5.freed", 32'(pr_ready), 32'd1);

    // reset mid-packet
    do_reset();
    pr_start = 1; tick(); pr_start = 0;
    for (int i = 0; i < 3; i++) begin
      pr_valid = 1; pr_data = 8'hB0 + 8'(i); tick();
    end
    reset_n = 0; #2;
    chk("t6.we", 32'(ram_we), 32'd0);
    chk("t6.wadr", 32'(ram_wr_adr), 32'd0);
    chk("t6.wdat", 32'(ram_wr_dat), 32'd0);
    chk("t6.ready", 32'(pr_ready), 32'd1);
    chk("t6.avail", 32'(app_avail), 32'd0);
    pr_valid = 0;
    tick(); tick();
    reset_n = 1;
    send(2, 8'hC0, 1);
    wait_avail("t6.avail2", 5);
    chk("t6.len2", 32'(app_len), 32'd2);
    chk("t6.mem0", 32'(mem[0]), 32'hC0);
    chk("t6.mem1", 32'(mem[1]), 32'hC1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb2_ep_buf_ctrl.md
Name: usb2_ep_buf_ctrl

Overview:
Ping-pong buffer manager for one USB2 OUT endpoint. Owns the write port and sequences the read address of the 1024x8 endpoint RAM, which is split into two 512-byte halves (bank 0: 0x000-0x1FF, bank 1: 0x200-0x3FF). Accepts packet bytes from the protocol layer, commits or discards each packet, and hands full banks to the application side in order. Drives the ACK/NAK decision via pr_ready.

Parameters:
ADDR_W, 10, RAM address width; bank size is 2^(ADDR_W-1) bytes.
LEN_W, 10, width of the byte-count field; must satisfy 2^LEN_W > bank size.

Ports:
phy_clk  in  1  single clock for all logic, including both RAM ports.
reset_n  in  1  asynchronous, active-low reset.
pr_start  in  1  pulse; a data packet begins.
pr_valid  in  1  pr_data is valid this cycle.
pr_data  in  8  received byte.
pr_commit  in  1  pulse; packet ended with good CRC.
pr_abort  in  1  pulse; packet ended with bad CRC or timeout.
pr_ready  out  1  a free bank exists; protocol layer ACKs if 1, NAKs if 0.
pr_overflow  out  1  one-cycle pulse; a byte arrived with the bank already at 512 bytes.
ram_we  out  1  RAM write enable.
ram_wr_adr  out  ADDR_W  RAM write address.
ram_wr_dat  out  8  RAM write data.
ram_rd_adr  out  ADDR_W  RAM read address; the RAM registers it, so data appears the following cycle.
app_avail  out  1  a committed bank is presented to the application.
app_len  out  LEN_W  byte count of the presented bank (0 to 512).
app_rd  in  1  pulse; read the next byte.
app_dat_valid  out  1  RAM read data is valid this cycle, one cycle after an accepted app_rd.
app_done  in  1  pulse; application releases the presented bank.

Behaviour:
- Reset values: pr_ready=1, pr_overflow=0, ram_we=0, ram_wr_adr=0, ram_wr_dat=0, ram_rd_adr=0, app_avail=0, app_len=0, app_dat_valid=0.
- Reset state: full[1:0]=0, wr_sel=0, rd_sel=0, both lengths=0, write FSM in W_IDLE, read FSM in R_IDLE.
- pr_ready = ~full[wr_sel]. It is combinational from registers and is valid in any write state.
- Write FSM states: W_IDLE, W_RECV, W_DROP.
  - W_IDLE, pr_start with ~full[wr_sel]: go to W_RECV and set wcnt=0.
  - W_IDLE, pr_start with full[wr_sel]: go to W_DROP.
- W_RECV, per pr_valid byte:
  - If wcnt<512: registered write; ram_we=1 next cycle, ram_wr_adr={wr_sel,wcnt[8:0]}, ram_wr_dat=pr_data; then wcnt increments.
  - If wcnt==512: no write, pr_overflow pulses, go to W_DROP.
- W_RECV, pr_commit:
  - Set len[wr_sel]=wcnt and full[wr_sel]=1.
  - Toggle wr_sel.
  - Go to W_IDLE.
  - A zero-length packet commits with len=0.
  - If pr_valid and pr_commit coincide, the byte is written and counted first.
- W_RECV, pr_abort: go to W_IDLE; full, len and wr_sel are unchanged.
- W_DROP: ignore all bytes; pr_commit or pr_abort returns to W_IDLE with no state change.
- pr_start in W_RECV or W_DROP: restart; the current packet is discarded and the W_IDLE start rule is applied.
- Read FSM states: R_IDLE, R_OWN.
  - R_IDLE, full[rd_sel]=1: go to R_OWN and set rcnt=0.
  - In R_OWN: app_avail=1, app_len=len[rd_sel].
- R_OWN, app_rd with rcnt<app_len: ram_rd_adr={rd_sel,rcnt[8:0]} is registered; app_dat_valid=1 the next cycle; rcnt increments.
- Ignored app_rd cases: app_rd with rcnt==app_len, and app_rd in R_IDLE. Neither has any effect.
- R_OWN, app_done: clear full[rd_sel], toggle rd_sel, go to R_IDLE; app_avail drops the next cycle.
- app_done in R_IDLE is ignored.
- Simultaneous commit on wr_sel and app_done on rd_sel (different banks): both take effect in the same cycle. A bank freed this cycle is visible to pr_ready next cycle.
- Reset asserted mid-packet: all state returns to the reset values immediately; no partial commit.

Optional Feature:
USB2_EP_BUF_ERR_CNT_EN
- Defined: adds output err_cnt[7:0], reset 0. It increments by 1 on each pr_start that enters W_DROP (NAK), each pr_overflow, and each pr_abort from W_RECV.
- err_cnt saturates at 255.
- More than one increment event in the same cycle adds only 1.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- 4-byte packet 0xA1..0xA4 then commit -> RAM 0x000-0x003 holds the bytes; app_avail=1, app_len=4; 4 app_rd pulses -> ram_rd_adr 0x000..0x003, app_dat_valid each following cycle.
- Two packets (10 and 3 bytes) committed, no app_done -> pr_ready=0; third pr_start is NAKed with no RAM writes; app_done -> app_len=3 bank 1 presented; pr_ready=1.
- 513 bytes in one packet -> pr_overflow pulses on byte 513; commit ignored; full unchanged; pr_ready stays 1.
- Packet of 5 bytes then pr_abort -> app_avail stays 0; next packet writes from 0x000 again.
- Zero-length commit -> app_avail=1, app_len=0; app_rd gives no app_dat_valid; app_done frees the bank.
- reset_n low mid-packet, then high -> all outputs at reset values; a fresh 2-byte packet lands in bank 0.
